// File: rtl/int_ctrl.sv
// Interrupt request controller feeding CP0 HWInt[7:2]: latches, masks and prioritises
// six sources, presents one stable one-hot request and tracks the accepted one until EOI/eret.
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            int_taken,
    input  logic            eret_w,
    output logic [NSRC-1:0] hwint,
    output logic [2:0]      cur_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    function automatic logic [2:0] onehot_to_id(input logic [NSRC-1:0] oh);
        logic [2:0] id;
        id = 3'd7;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (oh[i]) id = 3'(i);
        end
        return id;
    endfunction

    state_t          state_q, state_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] epend_q, epend_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] inserv_q, inserv_d;
    logic [NSRC-1:0] hwint_q, hwint_d;
    logic [2:0]      cur_id_q, cur_id_d;
    logic            gap_q, gap_d;

    logic            wr_mode_s, wr_mask_s, wr_pend_s, wr_eoi_s, take_s;
    logic [NSRC-1:0] rise_s, clr_s, pending_s, eligible_s, winner_s;
    logic            unused_wdata_s;

    assign wr_mode_s      = we && (addr == 2'd0);
    assign wr_mask_s      = we && (addr == 2'd1);
    assign wr_pend_s      = we && (addr == 2'd2);
    assign wr_eoi_s       = we && (addr == 2'd3);
    assign take_s         = (state_q == ST_REQ) && int_taken;
    assign rise_s         = irq_src & ~src_q;
    assign pending_s      = (mode_q & epend_q) | (~mode_q & irq_src);
    assign eligible_s     = pending_s & mask_q;
    assign winner_s       = eligible_s & (~eligible_s + {{(NSRC-1){1'b0}}, 1'b1});
    assign unused_wdata_s = ^wdata[31:NSRC];

    // Register file updates and edge-latched pending; set beats clear, level bits never latch.
    always_comb begin
        mode_d = wr_mode_s ? wdata[NSRC-1:0] : mode_q;
        mask_d = wr_mask_s ? wdata[NSRC-1:0] : mask_q;
        clr_s  = (wr_pend_s ? wdata[NSRC-1:0] : {NSRC{1'b0}})
               | (take_s ? hwint_q : {NSRC{1'b0}});
        epend_d = mode_d & (rise_s | (epend_q & ~clr_s));
    end

    // Request/service FSM; gap_q keeps hwint low for one IDLE cycle after a service ends.
    always_comb begin
        state_d  = state_q;
        hwint_d  = hwint_q;
        inserv_d = inserv_q;
        gap_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hwint_d = {NSRC{1'b0}};
                if ((eligible_s != {NSRC{1'b0}}) && !gap_q) begin
                    hwint_d = winner_s;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_taken) begin
                    inserv_d = hwint_q;
                    hwint_d  = {NSRC{1'b0}};
                    state_d  = ST_SVC;
                end else if ((hwint_q & eligible_s) == {NSRC{1'b0}}) begin
                    hwint_d = {NSRC{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SVC: begin
                hwint_d = {NSRC{1'b0}};
                if (wr_eoi_s || eret_w) begin
                    inserv_d = {NSRC{1'b0}};
                    gap_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_SVC;
                end
            end
            default: begin
                hwint_d  = {NSRC{1'b0}};
                inserv_d = {NSRC{1'b0}};
                state_d  = ST_IDLE;
            end
        endcase
        cur_id_d = onehot_to_id(inserv_d);
    end

    // Bus read mux, combinational on addr.
    always_comb begin
        case (addr)
            2'd0:    rdata = {{(32-NSRC){1'b0}}, mode_q};
            2'd1:    rdata = {{(32-NSRC){1'b0}}, mask_q};
            2'd2:    rdata = {{(32-NSRC){1'b0}}, pending_s};
            2'd3:    rdata = {{(32-NSRC){1'b0}}, inserv_q};
            default: rdata = 32'd0;
        endcase
    end

    // State and register flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= {NSRC{1'b0}};
            mask_q   <= {NSRC{1'b0}};
            epend_q  <= {NSRC{1'b0}};
            src_q    <= {NSRC{1'b0}};
            inserv_q <= {NSRC{1'b0}};
            hwint_q  <= {NSRC{1'b0}};
            cur_id_q <= 3'd7;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            epend_q  <= epend_d;
            src_q    <= irq_src;
            inserv_q <= inserv_d;
            hwint_q  <= hwint_d;
            cur_id_q <= cur_id_d;
            gap_q    <= gap_d;
        end
    end

    assign hwint  = hwint_q;
    assign cur_id = cur_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued as stimulus is applied
// and drained against the DUT outputs one step later.
module tb_int_ctrl;

    localparam int K_HW = 0;
    localparam int K_ID = 1;
    localparam int K_RD = 2;

    typedef struct {
        int          kind;
        logic [1:0]  a;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [5:0]  irq_src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_taken;
    logic        eret_w;
    logic [5:0]  hwint;
    logic [2:0]  cur_id;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .int_taken(int_taken),
        .eret_w   (eret_w),
        .hwint    (hwint),
        .cur_id   (cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] a, input string tag, input logic [31:0] e);
        exp_t t;
        t.kind = kind;
        t.a    = a;
        t.tag  = tag;
        t.exp  = e;
        sb_q.push_back(t);
    endtask

    task automatic exp_hw(input string tag, input logic [5:0] v);
        push(K_HW, 2'd0, tag, {26'd0, v});
    endtask

    task automatic exp_id(input string tag, input logic [2:0] v);
        push(K_ID, 2'd0, tag, {29'd0, v});
    endtask

    task automatic exp_rd(input logic [1:0] a, input string tag, input logic [31:0] v);
        push(K_RD, a, tag, v);
    endtask

    task automatic drain();
        exp_t t;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            case (t.kind)
                K_HW: check_eq(t.tag, {26'd0, hwint}, t.exp);
                K_ID: check_eq(t.tag, {29'd0, cur_id}, t.exp);
                default: begin
                    addr = t.a;
                    #1;
                    check_eq(t.tag, rdata, t.exp);
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic pulse_taken();
        int_taken = 1'b1;
        tick();
        int_taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; irq_src = 6'd0; we = 1'b0; addr = 2'd0;
        wdata = 32'd0; int_taken = 1'b0; eret_w = 1'b0;
        tick(); tick();
        exp_hw("rst_hwint", 6'd0);
        exp_id("rst_cur_id", 3'd7);
        exp_rd(2'd0, "rst_mode", 32'd0);
        exp_rd(2'd1, "rst_mask", 32'd0);
        exp_rd(2'd2, "rst_pend", 32'd0);
        exp_rd(2'd3, "rst_inserv", 32'd0);
        drain();
        reset = 1'b1;
        tick();

        // Edge source 0: two-cycle latency to hwint
        bus_wr(2'd1, 32'h3F);
        bus_wr(2'd0, 32'h01);
        irq_src = 6'b000001;
        tick();
        irq_src = 6'd0;
        exp_rd(2'd2, "t1_pend", 32'h01);
        exp_hw("t1_hw_early", 6'd0);
        drain();
        tick();
        exp_hw("t1_hw", 6'b000001);
        exp_id("t1_cur_id", 3'd7);
        drain();

        // Accept, then return via eret
        pulse_taken();
        exp_hw("t2_hw", 6'd0);
        exp_rd(2'd3, "t2_inserv", 32'h01);
        exp_id("t2_cur_id", 3'd0);
        exp_rd(2'd2, "t2_pend", 32'h00);
        drain();
        eret_w = 1'b1;
        tick();
        eret_w = 1'b0;
        exp_id("t2_eret_id", 3'd7);
        exp_rd(2'd3, "t2_eret_inserv", 32'h00);
        drain();
        tick();
        exp_hw("t2_idle_hw", 6'd0);
        drain();

        // Level sources 3 and 5; dropping the held one re-arbitrates through IDLE
        irq_src = 6'b101000;
        tick();
        exp_hw("t3_hw3", 6'b001000);
        drain();
        irq_src = 6'b100000;
        tick();
        exp_hw("t3_drop", 6'd0);
        drain();
        tick();
        exp_hw("t3_hw5", 6'b100000);
        drain();
        pulse_taken();
        exp_id("t3_cur_id", 3'd5);
        drain();
        irq_src = 6'd0;
        bus_wr(2'd3, 32'd0);
        exp_id("t3_eoi_id", 3'd7);
        drain();

        // Held bit 4 is not pre-empted by a higher-priority edge; EOI gap
        bus_wr(2'd0, 32'h03);
        irq_src = 6'b010000;
        tick();
        exp_hw("t4_hw4", 6'b010000);
        drain();
        irq_src = 6'b010010;
        tick();
        irq_src = 6'b010000;
        tick();
        exp_hw("t4_hold", 6'b010000);
        exp_rd(2'd2, "t4_pend", 32'h12);
        drain();
        pulse_taken();
        exp_hw("t4_svc_hw", 6'd0);
        exp_id("t4_cur_id", 3'd4);
        drain();
        irq_src = 6'd0;
        bus_wr(2'd3, 32'd0);
        exp_hw("t4_eoi_k", 6'd0);
        exp_id("t4_eoi_id", 3'd7);
        drain();
        tick();
        exp_hw("t4_eoi_k1", 6'd0);
        drain();
        tick();
        exp_hw("t4_eoi_k2", 6'b000010);
        drain();
        pulse_taken();
        exp_id("t4_cur_id1", 3'd1);
        exp_rd(2'd2, "t4_pend_clr", 32'h00);
        drain();
        eret_w = 1'b1;
        tick();
        eret_w = 1'b0;
        tick();

        // Masked edge source 2, W1C, and set-beats-clear
        bus_wr(2'd0, 32'h07);
        bus_wr(2'd1, 32'h3B);
        irq_src = 6'b000100;
        tick();
        irq_src = 6'd0;
        exp_rd(2'd2, "t5_pend", 32'h04);
        drain();
        tick();
        exp_hw("t5_masked", 6'd0);
        drain();
        bus_wr(2'd2, 32'h04);
        exp_rd(2'd2, "t5_w1c", 32'h00);
        drain();
        irq_src = 6'b000100;
        bus_wr(2'd2, 32'h04);
        irq_src = 6'd0;
        exp_rd(2'd2, "t5_set_wins", 32'h04);
        drain();
        bus_wr(2'd2, 32'h04);

        // Asynchronous reset mid-REQ and mid-SVC
        bus_wr(2'd0, 32'h00);
        bus_wr(2'd1, 32'h3F);
        irq_src = 6'b001000;
        tick();
        exp_hw("t6_req_hw", 6'b001000);
        drain();
        #2 reset = 1'b0;
        #1;
        exp_hw("t6_req_rst_hw", 6'd0);
        exp_id("t6_req_rst_id", 3'd7);
        drain();
        @(posedge clk);
        #1 reset = 1'b1;
        bus_wr(2'd1, 32'h3F);
        tick();
        exp_hw("t6_req2_hw", 6'b001000);
        drain();
        pulse_taken();
        exp_id("t6_svc_id", 3'd3);
        exp_rd(2'd3, "t6_svc_inserv", 32'h08);
        drain();
        #2 reset = 1'b0;
        #1;
        exp_hw("t6_svc_rst_hw", 6'd0);
        exp_id("t6_svc_rst_id", 3'd7);
        exp_rd(2'd3, "t6_svc_rst_inserv", 32'h00);
        exp_rd(2'd1, "t6_svc_rst_mask", 32'h00);
        drain();
        @(posedge clk);
        #1 reset = 1'b1;
        irq_src = 6'b000001;
        tick();
        tick();
        exp_hw("t6_post_hw", 6'd0);
        exp_rd(2'd2, "t6_post_pend", 32'h01);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt request controller between the peripheral sources (timers, external lines) and the CP0 `HWInt[7:2]` input. It latches and masks six requests, picks one winner by fixed priority, and presents it to CP0 as a stable one-hot `hwint`. It tracks the accepted request through service until software signals end-of-interrupt or the handler retires `eret`. Registers sit on the bridge bus and are accessed like other peripherals.

## Interface
Parameters:
- NSRC, 6, number of sources (fixed to CP0 HWInt width; source i drives HWInt[i+2])

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- irq_src  in  6  raw requests; bit 0 highest priority, bit 5 lowest
- we  in  1  bus write strobe
- addr  in  2  register select (bus address bits [3:2])
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational on addr
- int_taken  in  1  one-cycle pulse: CP0 entered an interrupt (exc_int with ExcCode 0)
- eret_w  in  1  one-cycle pulse: eret retired in W
- hwint  out  6  registered one-hot request to CP0 HWInt[7:2]
- cur_id  out  3  index of the in-service source; 3'd7 when none

## Operation
- Registers (bits 31:6 read 0, ignored on write):
  - addr 0 MODE: bit i = 1 edge-triggered, 0 level.
  - addr 1 MASK: bit i = 1 enabled.
  - addr 2 PENDING: read-only view; a write of 1 to bit i clears edge-latched pending i.
  - addr 3 INSERV: reads one-hot in-service source; any write is EOI.
- Edge detection: `src_q` <= irq_src each cycle. A rise is `irq_src & ~src_q`.
- Pending bit i:
  - Edge mode: set on rise. Cleared by W1C, or by int_taken while i is the presented winner. Set wins over clear in the same cycle.
  - Level mode: equals irq_src[i], combinationally. W1C has no effect.
  - Changing MODE from edge to level discards the latched bit.
- eligible = pending & MASK. The winner is the lowest-index eligible bit.
- FSM (state register, 2 bits):
  - IDLE: hwint = 0. If eligible != 0, go to REQ and load hwint with the winner's one-hot.
  - REQ: hwint is held stable. A higher-priority source becoming eligible does not change it.
    - int_taken: latch inserv = hwint, clear hwint, clear that pending bit if in edge mode, go to SVC.
    - Held bit no longer eligible (masked, W1C, or level dropped) and no int_taken: clear hwint, go to IDLE.
  - SVC: hwint = 0, with no nesting. EOI write or eret_w clears inserv and returns to IDLE. Pending continues to accumulate meanwhile.
- cur_id = index of inserv, or 7 when inserv = 0.
- Simultaneous events:
  - int_taken with the held bit dropping in the same cycle: int_taken wins and the FSM goes to SVC.
  - EOI and eret_w in the same cycle: a single return to IDLE.
- Bus writes take effect at the clock edge. A write to MASK at edge k affects eligibility evaluated in cycle k+1.

## Timing
- Reset (asynchronous assert, synchronous release on clk) sets:
  - MODE=0, MASK=0, pending=0, src_q=0, inserv=0
  - state=IDLE, hwint=0, cur_id=7
  - rdata follows addr with these values.
- Reset mid-REQ or mid-SVC drops hwint immediately and abandons the service.
- Edge source rising in the cycle before edge k:
  - pending set at edge k
  - hwint valid after edge k+1, a 2-cycle latency
- Level source: hwint valid after the first edge at which it is eligible, a 1-cycle latency.
- hwint changes only at clock edges. It never glitches within a cycle and is never multi-hot.
- After EOI or eret at edge k, IDLE evaluation occurs in cycle k+1. The next hwint appears at edge k+2 at the earliest.

## Test plan
- Reset release, then MASK=0x3F, MODE=0x01, pulse irq_src[0] for 1 cycle -> PENDING=0x01 next cycle; hwint=6'b000001 one cycle later; cur_id=7.
- From that state, pulse int_taken -> hwint=0, INSERV=0x01, cur_id=0, PENDING=0x00. Pulse eret_w -> cur_id=7, FSM IDLE.
- Level irq_src[3] and irq_src[5] both high, MASK=0x3F -> hwint=6'b001000. Then drop irq_src[3] with no int_taken -> hwint=0 for one cycle, then hwint=6'b100000.
- In REQ holding bit 4, raise edge source 1 -> hwint stays 6'b010000 until int_taken. After EOI write, hwint=6'b000010 two edges later.
- Edge source 2 with MASK bit 2 = 0: pulse -> PENDING=0x04, hwint=0. Write PENDING=0x04 -> PENDING=0x00. Rise in the same cycle as the W1C -> PENDING stays 0x04.
- Assert reset low asynchronously while in SVC with hwint and inserv nonzero -> all outputs zero (cur_id=7) before the next clk edge. After release, MASK=0, so a raised source produces no hwint.
